// File: rtl/pmp_cfg_regfile.sv
// PMP configuration/address register file with a one-cycle NAPOT mask recompute
// after every accepted CSR write. Read port is registered with one-cycle latency.
package pmp_cfg_regfile_pkg;

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

endpackage

module pmp_cfg_regfile
    import pmp_cfg_regfile_pkg::*;
#(
    parameter int PMP_CHANNEL_NUM = 32,
    parameter int ADDR_WIDTH      = 32,
    localparam int IW = (PMP_CHANNEL_NUM > 1) ? $clog2(PMP_CHANNEL_NUM) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        csr_wr_valid,
    output logic                                        csr_wr_ready,
    input  logic                                        csr_wr_sel,
    input  logic [IW-1:0]                               csr_wr_idx,
    input  logic [ADDR_WIDTH-1:0]                       csr_wr_data,
    input  logic                                        csr_rd_valid,
    input  logic                                        csr_rd_sel,
    input  logic [IW-1:0]                               csr_rd_idx,
    output logic [ADDR_WIDTH-1:0]                       csr_rd_data,
    output pmp_cfg_t [PMP_CHANNEL_NUM-1:0]              v_pmp_cfg,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_pmp_addr,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_pmp_napot_mask,
    output logic                                        upd_busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_e;

    state_e                                      state_q, state_d;
    pmp_cfg_t [PMP_CHANNEL_NUM-1:0]              cfg_q, cfg_d;
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]                       rd_data_q, rd_data_d;
    logic [IW-1:0]                               upd_idx_q, upd_idx_d;
    logic                                        upd_hit_q, upd_hit_d;
    logic                                        wr_fire;
    logic [PMP_CHANNEL_NUM-1:0]                  tor_lock;

    // W without R is not a legal permission set; reserved bits always read 0.
    function automatic pmp_cfg_t legalize_cfg(input logic [7:0] raw);
        pmp_cfg_t c;
        c      = pmp_cfg_t'(raw);
        c.rsvd = 2'b00;
        if (c.w && !c.r) begin
            c.w = 1'b0;
        end
        return c;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] calc_mask(input pmp_cfg_t c,
                                                        input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] m;
        m = '1;
        if (c.a == A_NAPOT) begin
            m = ~(a ^ (a + ADDR_WIDTH'(1)));
        end
        return m;
    endfunction

    always_comb begin
        wr_fire = csr_wr_valid && (state_q == S_IDLE);
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (csr_wr_valid) state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // addr[i] is the top of a locked TOR range belonging to entry i+1.
    always_comb begin
        tor_lock = '0;
        for (int i = 0; i < PMP_CHANNEL_NUM - 1; i++) begin
            tor_lock[i] = cfg_q[i+1].l && (cfg_q[i+1].a == A_TOR);
        end
    end

    always_comb begin
        cfg_d     = cfg_q;
        addr_d    = addr_q;
        upd_idx_d = upd_idx_q;
        upd_hit_d = upd_hit_q;
        if (wr_fire) begin
            upd_idx_d = csr_wr_idx;
            upd_hit_d = 1'b0;
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                if (csr_wr_idx == IW'(i)) begin
                    upd_hit_d = 1'b1;
                    if (!csr_wr_sel) begin
                        if (!cfg_q[i].l) cfg_d[i] = legalize_cfg(csr_wr_data[7:0]);
                    end else begin
                        if (!cfg_q[i].l && !tor_lock[i]) addr_d[i] = csr_wr_data;
                    end
                end
            end
        end
    end

    // Recompute uses the registers as already updated at the acceptance edge.
    always_comb begin
        mask_d = mask_q;
        if (state_q == S_UPDATE && upd_hit_q) begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                if (upd_idx_q == IW'(i)) begin
                    mask_d[i] = calc_mask(cfg_q[i], addr_q[i]);
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (csr_rd_valid) begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                if (csr_rd_idx == IW'(i)) begin
                    rd_data_d = csr_rd_sel ? addr_q[i] : ADDR_WIDTH'(cfg_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '1;
            rd_data_q <= '0;
            upd_idx_q <= '0;
            upd_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            upd_idx_q <= upd_idx_d;
            upd_hit_q <= upd_hit_d;
        end
    end

    assign csr_wr_ready     = (state_q == S_IDLE);
    assign upd_busy         = (state_q == S_UPDATE);
    assign csr_rd_data      = rd_data_q;
    assign v_pmp_cfg        = cfg_q;
    assign v_pmp_addr       = addr_q;
    assign v_pmp_napot_mask = mask_q;

endmodule

// File: tb/tb_pmp_cfg_regfile.sv
// Self-checking bench for pmp_cfg_regfile: directed scenarios plus random NAPOT
// writes; read data checked through an expected-value queue.
module tb_pmp_cfg_regfile;
  import pmp_cfg_regfile_pkg::*;

  localparam int N  = 32;
  localparam int AW = 32;
  localparam int IW = 5;

  logic                    clk;
  logic                    rst;
  logic                    csr_wr_valid;
  logic                    csr_wr_ready;
  logic                    csr_wr_sel;
  logic [IW-1:0]           csr_wr_idx;
  logic [AW-1:0]           csr_wr_data;
  logic                    csr_rd_valid;
  logic                    csr_rd_sel;
  logic [IW-1:0]           csr_rd_idx;
  logic [AW-1:0]           csr_rd_data;
  pmp_cfg_t [N-1:0]        v_pmp_cfg;
  logic [N-1:0][AW-1:0]    v_pmp_addr;
  logic [N-1:0][AW-1:0]    v_pmp_napot_mask;
  logic                    upd_busy;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] rd_exp;
  int n_checks = 0;
  int n_pass   = 0;

  pmp_cfg_regfile #(.PMP_CHANNEL_NUM(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_wr_sel(csr_wr_sel), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
    .csr_rd_valid(csr_rd_valid), .csr_rd_sel(csr_rd_sel), .csr_rd_idx(csr_rd_idx),
    .csr_rd_data(csr_rd_data),
    .v_pmp_cfg(v_pmp_cfg), .v_pmp_addr(v_pmp_addr),
    .v_pmp_napot_mask(v_pmp_napot_mask), .upd_busy(upd_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic sel, input logic [IW-1:0] idx, input logic [AW-1:0] data);
    csr_wr_valid = 1'b1;
    csr_wr_sel   = sel;
    csr_wr_idx   = idx;
    csr_wr_data  = data;
    tick();
    csr_wr_valid = 1'b0;
  endtask

  task automatic write_settle(input logic sel, input logic [IW-1:0] idx, input logic [AW-1:0] data);
    do_write(sel, idx, data);
    tick();
  endtask

  task automatic rd_issue(input logic sel, input logic [IW-1:0] idx, input logic [AW-1:0] exp);
    exp_q.push_back(exp);
    csr_rd_valid = 1'b1;
    csr_rd_sel   = sel;
    csr_rd_idx   = idx;
    tick();
    csr_rd_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    csr_wr_valid = 1'b0; csr_wr_sel = 1'b0; csr_wr_idx = '0; csr_wr_data = '0;
    csr_rd_valid = 1'b0; csr_rd_sel = 1'b0; csr_rd_idx = '0;
    repeat (3) tick();
    n_checks++; if (csr_rd_data !== '0) $display("FAIL rst_rd_data got=%h exp=0", csr_rd_data); else n_pass++;
    rst = 1'b0;
    n_checks++; if (csr_wr_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", csr_wr_ready); else n_pass++;
    n_checks++; if (upd_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", upd_busy); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (v_pmp_napot_mask[i] !== 32'hFFFF_FFFF)
        $display("FAIL rst_mask[%0d] got=%h exp=ffffffff", i, v_pmp_napot_mask[i]);
      else n_pass++;
      n_checks++;
      if (v_pmp_cfg[i] !== 8'h00 || v_pmp_addr[i] !== '0)
        $display("FAIL rst_entry[%0d] got=%h/%h exp=00/0", i, v_pmp_cfg[i], v_pmp_addr[i]);
      else n_pass++;
    end
    rd_issue(1'b0, 5'd0, 32'h0);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rst_rd_cfg0 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    rd_issue(1'b1, 5'd31, 32'h0);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rst_rd_addr31 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
  endtask

  task automatic test_napot();
    do_write(1'b1, 5'd3, 32'h0000_1FFF);
    n_checks++; if (csr_wr_ready !== 1'b0) $display("FAIL napot_ready_a got=%b exp=0", csr_wr_ready); else n_pass++;
    n_checks++; if (upd_busy !== 1'b1) $display("FAIL napot_busy_a got=%b exp=1", upd_busy); else n_pass++;
    n_checks++; if (v_pmp_addr[3] !== 32'h0000_1FFF) $display("FAIL napot_addr3 got=%h exp=00001fff", v_pmp_addr[3]); else n_pass++;
    tick();
    n_checks++; if (csr_wr_ready !== 1'b1) $display("FAIL napot_ready_back got=%b exp=1", csr_wr_ready); else n_pass++;
    n_checks++; if (v_pmp_napot_mask[3] !== 32'hFFFF_FFFF) $display("FAIL napot_mask_off got=%h exp=ffffffff", v_pmp_napot_mask[3]); else n_pass++;
    do_write(1'b0, 5'd3, 32'h18);
    n_checks++; if (csr_wr_ready !== 1'b0) $display("FAIL napot_ready_c got=%b exp=0", csr_wr_ready); else n_pass++;
    n_checks++; if (v_pmp_cfg[3] !== 8'h18) $display("FAIL napot_cfg3 got=%h exp=18", v_pmp_cfg[3]); else n_pass++;
    n_checks++; if (v_pmp_napot_mask[3] !== 32'hFFFF_FFFF) $display("FAIL napot_mask_early got=%h exp=ffffffff", v_pmp_napot_mask[3]); else n_pass++;
    tick();
    n_checks++; if (v_pmp_napot_mask[3] !== 32'hFFFF_C000) $display("FAIL napot_mask3 got=%h exp=ffffc000", v_pmp_napot_mask[3]); else n_pass++;
    n_checks++; if (v_pmp_napot_mask[2] !== 32'hFFFF_FFFF) $display("FAIL napot_mask2 got=%h exp=ffffffff", v_pmp_napot_mask[2]); else n_pass++;
    rd_issue(1'b0, 5'd3, 32'h18);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL napot_rd_cfg3 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
  endtask

  task automatic test_lock();
    write_settle(1'b0, 5'd5, 32'h88);
    do_write(1'b0, 5'd5, 32'h00);
    n_checks++; if (csr_wr_ready !== 1'b0) $display("FAIL lock_handshake got=%b exp=0", csr_wr_ready); else n_pass++;
    tick();
    write_settle(1'b1, 5'd5, 32'h100);
    write_settle(1'b1, 5'd4, 32'h200);
    write_settle(1'b1, 5'd6, 32'h300);
    rd_issue(1'b1, 5'd5, 32'h0);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL lock_addr5 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    rd_issue(1'b1, 5'd4, 32'h0);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL lock_tor_addr4 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    rd_issue(1'b0, 5'd5, 32'h88);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL lock_cfg5 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    rd_issue(1'b1, 5'd6, 32'h300);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL lock_addr6 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
  endtask

  task automatic test_wlegal();
    write_settle(1'b0, 5'd2, 32'h62);
    rd_issue(1'b0, 5'd2, 32'h00);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL wlegal_62 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    write_settle(1'b0, 5'd2, 32'hFFFF_FF63);
    rd_issue(1'b0, 5'd2, 32'h03);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL wlegal_63 got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
  endtask

  task automatic test_same_cycle_rw();
    write_settle(1'b1, 5'd1, 32'h10);
    exp_q.push_back(32'h10);
    csr_wr_valid = 1'b1; csr_wr_sel = 1'b1; csr_wr_idx = 5'd1; csr_wr_data = 32'h20;
    csr_rd_valid = 1'b1; csr_rd_sel = 1'b1; csr_rd_idx = 5'd1;
    tick();
    csr_wr_valid = 1'b0; csr_rd_valid = 1'b0;
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rw_old got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    tick();
    rd_issue(1'b1, 5'd1, 32'h20);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rw_new got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
    tick();
    n_checks++; if (csr_rd_data !== '0) $display("FAIL rd_idle_zero got=%h exp=0", csr_rd_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    a = $urandom; b = $urandom;
    csr_wr_valid = 1'b1; csr_wr_sel = 1'b1; csr_wr_idx = 5'd8; csr_wr_data = a;
    tick();
    csr_wr_idx = 5'd9; csr_wr_data = b;
    n_checks++; if (csr_wr_ready !== 1'b0) $display("FAIL b2b_ready got=%b exp=0", csr_wr_ready); else n_pass++;
    tick();
    n_checks++; if (v_pmp_addr[9] !== '0) $display("FAIL b2b_held got=%h exp=0", v_pmp_addr[9]); else n_pass++;
    tick();
    csr_wr_valid = 1'b0;
    n_checks++; if (v_pmp_addr[8] !== a) $display("FAIL b2b_addr8 got=%h exp=%h", v_pmp_addr[8], a); else n_pass++;
    n_checks++; if (v_pmp_addr[9] !== b) $display("FAIL b2b_addr9 got=%h exp=%h", v_pmp_addr[9], b); else n_pass++;
    tick();
  endtask

  task automatic test_random_napot();
    for (int k = 0; k < 6; k++) begin
      logic [IW-1:0] idx;
      logic [AW-1:0] a, m;
      idx = IW'($urandom_range(10, 20));
      a   = $urandom;
      m   = ~(a ^ (a + 32'd1));
      write_settle(1'b1, idx, a);
      write_settle(1'b0, idx, 32'h1F);
      n_checks++;
      if (v_pmp_napot_mask[idx] !== m)
        $display("FAIL rnd_mask[%0d] got=%h exp=%h", idx, v_pmp_napot_mask[idx], m);
      else n_pass++;
      rd_issue(1'b1, idx, a);
      rd_exp = exp_q.pop_front();
      n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rnd_rd[%0d] got=%h exp=%h", idx, csr_rd_data, rd_exp); else n_pass++;
    end
  endtask

  task automatic test_reset_during_update();
    write_settle(1'b0, 5'd7, 32'h18);
    n_checks++; if (v_pmp_napot_mask[7] !== 32'hFFFF_FFFE) $display("FAIL rdu_mask_pre got=%h exp=fffffffe", v_pmp_napot_mask[7]); else n_pass++;
    do_write(1'b1, 5'd7, 32'hFF);
    n_checks++; if (upd_busy !== 1'b1) $display("FAIL rdu_busy_pre got=%b exp=1", upd_busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (upd_busy !== 1'b0 || csr_wr_ready !== 1'b1) $display("FAIL rdu_async got=%b/%b exp=0/1", upd_busy, csr_wr_ready); else n_pass++;
    n_checks++; if (v_pmp_cfg[5] !== 8'h00 || v_pmp_addr[7] !== '0) $display("FAIL rdu_clear got=%h/%h exp=00/0", v_pmp_cfg[5], v_pmp_addr[7]); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if (csr_wr_ready !== 1'b1) $display("FAIL rdu_ready got=%b exp=1", csr_wr_ready); else n_pass++;
    n_checks++; if (v_pmp_napot_mask[7] !== 32'hFFFF_FFFF) $display("FAIL rdu_mask got=%h exp=ffffffff", v_pmp_napot_mask[7]); else n_pass++;
    tick();
    n_checks++; if (v_pmp_napot_mask[7] !== 32'hFFFF_FFFF || upd_busy !== 1'b0) $display("FAIL rdu_mask_late got=%h/%b exp=ffffffff/0", v_pmp_napot_mask[7], upd_busy); else n_pass++;
    write_settle(1'b1, 5'd5, 32'h100);
    rd_issue(1'b1, 5'd5, 32'h100);
    rd_exp = exp_q.pop_front();
    n_checks++; if (csr_rd_data !== rd_exp) $display("FAIL rdu_unlock got=%h exp=%h", csr_rd_data, rd_exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_napot();
    test_lock();
    test_wlegal();
    test_same_cycle_rw();
    test_back_to_back();
    test_random_napot();
    test_reset_during_update();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pmp_cfg_regfile.md
PMP_CFG_REGFILE -- requirements
Module: pmp_cfg_regfile

Interface
REQ-001 SHALL have parameter PMP_CHANNEL_NUM, default 32, number of PMP entries (1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of every pmp address and mask.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port csr_wr_valid  input  1  write request.
REQ-006 SHALL have port csr_wr_ready  output  1  write accepted when valid&&ready.
REQ-007 SHALL have port csr_wr_sel  input  1  0 = cfg entry, 1 = addr entry.
REQ-008 SHALL have port csr_wr_idx  input  IW=$clog2(PMP_CHANNEL_NUM) (min 1)  entry index.
REQ-009 SHALL have port csr_wr_data  input  ADDR_WIDTH  write data; cfg uses bits [7:0].
REQ-010 SHALL have port csr_rd_valid, csr_rd_sel, csr_rd_idx  input  1/1/IW  read request.
REQ-011 SHALL have port csr_rd_data  output  ADDR_WIDTH  read data, registered.
REQ-012 SHALL have port v_pmp_cfg  output  pmp_cfg_t [PMP_CHANNEL_NUM]  per-entry cfg to the compare stage.
REQ-013 SHALL have port v_pmp_addr  output  ADDR_WIDTH [PMP_CHANNEL_NUM]  per-entry address, passed unchanged.
REQ-014 SHALL have port v_pmp_napot_mask  output  ADDR_WIDTH [PMP_CHANNEL_NUM]  per-entry compare mask.
REQ-015 SHALL have port upd_busy  output  1  high while a mask recompute is in flight.

Function
REQ-016 cfg byte layout SHALL be: bit0 R, bit1 W, bit2 X, bits[4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bits[6:5] reserved (stored 0), bit7 L.
REQ-017 FSM SHALL have two states: IDLE (csr_wr_ready=1) and UPDATE (csr_wr_ready=0, upd_busy=1).
REQ-018 An accepted write in IDLE SHALL update the target register at that edge and move to UPDATE; UPDATE SHALL return to IDLE after exactly one cycle.
REQ-019 In UPDATE, mask of the latched written index SHALL be recomputed and registered; all other masks unchanged.
REQ-020 Mask SHALL be ~(addr ^ (addr+1)) (ADDR_WIDTH wrap) when A=NAPOT, all ones otherwise.
REQ-021 Write to cfg[i] or addr[i] SHALL be discarded when cfg[i].L=1; handshake and UPDATE still occur.
REQ-022 Write to addr[i] SHALL also be discarded when i+1<PMP_CHANNEL_NUM, cfg[i+1].L=1 and cfg[i+1].A=TOR.
REQ-023 cfg write with W=1,R=0 SHALL store W=0; other fields as written.
REQ-024 Write with csr_wr_idx>=PMP_CHANNEL_NUM SHALL be accepted and change no state except FSM.
REQ-025 Read SHALL have 1-cycle latency: csr_rd_data at edge after csr_rd_valid holds the value before any same-cycle write; cfg reads zero-extended.
REQ-026 Read with out-of-range index, or csr_rd_valid=0, SHALL yield csr_rd_data=0 next cycle.
REQ-027 v_pmp_cfg/v_pmp_addr SHALL reflect a write from the cycle after acceptance; v_pmp_napot_mask from two cycles after.
REQ-028 Outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-029 On rst=1, all cfg=0 (A=OFF, L=0), all addr=0, all masks all-ones, csr_rd_data=0, FSM=IDLE, upd_busy=0, asynchronously.
REQ-030 Reset during UPDATE SHALL abort the recompute; csr_wr_ready=1 in the first cycle after rst deasserts.
REQ-031 Lock bits SHALL be clearable only by reset.

Verification
REQ-032 Reset release, read cfg[0] and addr[31] -> csr_rd_data=0; all masks 0xFFFFFFFF; csr_wr_ready=1.
REQ-033 Write addr[3]=0x0000_1FFF then cfg[3]=0x18 (NAPOT) -> cycle after cfg UPDATE v_pmp_napot_mask[3]=0xFFFF_C000; csr_wr_ready low one cycle after each write.
REQ-034 Write cfg[5]=0x88 (L, TOR), then addr[5]=0x100 and addr[4]=0x200 -> both addr unchanged (0); cfg[5] reads 0x88.
REQ-035 Write cfg[2]=0x62 (W only, reserved set) -> reads back 0x00.
REQ-036 Same-cycle read and write of addr[1] (old 0x10, new 0x20) -> csr_rd_data=0x10; following read 0x20.
REQ-037 Assert rst during UPDATE for addr[7] NAPOT -> mask[7]=all ones, upd_busy=0, csr_wr_ready=1 after release.
